// File: rtl/pgm_irq_ctrl.sv
// rtl/pgm_irq_ctrl.sv - PGM 68000 interrupt controller: VBLANK/timer/sound sources, IPL encode, IACK autovector
module pgm_irq_ctrl #(
  parameter int PRESCALE = 200,
  parameter int TMR_W    = 16
) (
  input  logic        fixed_20m_clk,
  input  logic        reset,
  input  logic        vblank,
  input  logic        snd_irq,
  input  logic        reg_cs,
  input  logic        reg_we,
  input  logic [1:0]  reg_addr,
  input  logic [15:0] reg_din,
  output logic [15:0] reg_dout,
  input  logic        as_n,
  input  logic [2:0]  fc,
  input  logic [2:0]  ack_lvl,
  output logic [2:0]  ipl_n,
  output logic        vpa_n,
  output logic [2:0]  pending
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PSC_MAX = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {IDLE, ACK, HOLD} iack_state_t;

  iack_state_t      state_q;
  logic             vpa_n_q;
  logic [2:0]       ipl_n_q, ipl_n_d;
  logic [2:0]       mask_q;
  logic [2:0]       pend_q, pend_d;
  logic             run_q;
  logic             vbl_prev_q;
  logic [TMR_W-1:0] reload_q;
  logic [TMR_W-1:0] cnt_q;
  logic [PW-1:0]    presc_q;

  logic       wr_mask, wr_reload, wr_pend, wr_ctrl;
  logic       iack_det, tick, tmr_fire, vbl_edge;
  logic [2:0] iack_clr, w1c_clr, set_bits, active;

  always_comb begin
    wr_mask   = reg_cs && reg_we && (reg_addr == 2'd0);
    wr_reload = reg_cs && reg_we && (reg_addr == 2'd1);
    wr_pend   = reg_cs && reg_we && (reg_addr == 2'd2);
    wr_ctrl   = reg_cs && reg_we && (reg_addr == 2'd3);

    tick     = run_q && (presc_q == PSC_MAX);
    tmr_fire = tick && (cnt_q == '0);
    vbl_edge = vblank && !vbl_prev_q;
    set_bits = {vbl_edge, tmr_fire, snd_irq};

    iack_det = (state_q == IDLE) && !as_n && (fc == 3'b111);
    iack_clr = 3'b000;
    if (iack_det) begin
      case (ack_lvl)
        3'd6:    iack_clr = 3'b100;
        3'd4:    iack_clr = 3'b010;
        3'd2:    iack_clr = 3'b001;
        default: iack_clr = 3'b000;
      endcase
    end
    w1c_clr = wr_pend ? reg_din[2:0] : 3'b000;

    // A new event in the same cycle always wins over any clear of that bit.
    pend_d = (pend_q & ~(iack_clr | w1c_clr)) | set_bits;

    active = pend_q & mask_q;
    if (active[2])      ipl_n_d = ~3'd6;
    else if (active[1]) ipl_n_d = ~3'd4;
    else if (active[0]) ipl_n_d = ~3'd2;
    else                ipl_n_d = 3'b111;
  end

  always_ff @(posedge fixed_20m_clk or posedge reset) begin
    if (reset) begin
      mask_q     <= 3'b000;
      pend_q     <= 3'b000;
      run_q      <= 1'b0;
      vbl_prev_q <= 1'b0;
      ipl_n_q    <= 3'b111;
    end else begin
      if (wr_mask) mask_q <= reg_din[2:0];
      if (wr_ctrl) run_q <= reg_din[0];
      pend_q     <= pend_d;
      vbl_prev_q <= vblank;
      ipl_n_q    <= ipl_n_d;
    end
  end

  // Timer: counter sits at reload while stopped; a RELOAD write restarts the period.
  always_ff @(posedge fixed_20m_clk or posedge reset) begin
    if (reset) begin
      reload_q <= '0;
      cnt_q    <= '0;
      presc_q  <= '0;
    end else if (wr_reload) begin
      reload_q <= TMR_W'(reg_din);
      cnt_q    <= TMR_W'(reg_din);
      presc_q  <= '0;
    end else if (!run_q) begin
      cnt_q   <= reload_q;
      presc_q <= '0;
    end else if (tick) begin
      presc_q <= '0;
      cnt_q   <= (cnt_q == '0) ? reload_q : cnt_q - TMR_W'(1);
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  always_ff @(posedge fixed_20m_clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      vpa_n_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: if (iack_det) state_q <= ACK;
        ACK: begin
          vpa_n_q <= 1'b0;
          state_q <= HOLD;
        end
        HOLD: if (as_n) begin
          vpa_n_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          vpa_n_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    case (reg_addr)
      2'd0:    reg_dout = {13'b0, mask_q};
      2'd1:    reg_dout = 16'(reload_q);
      2'd2:    reg_dout = {13'b0, pend_q};
      default: reg_dout = {15'b0, run_q};
    endcase
  end

  assign ipl_n   = ipl_n_q;
  assign vpa_n   = vpa_n_q;
  assign pending = pend_q;

endmodule
